// File: rtl/sha256_pkg.sv
// SHA-256/224 constants, FSM state type and the round helper functions
// shared by the iterative core and its round datapath.
package sha256_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUND  = 2'd1,
        FINAL  = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    // Index 0 holds a / H0, index 7 holds h / H7.
    typedef logic [7:0][31:0]  wv_t;
    // Message window: index 0 is W[t] (oldest), index 15 is W[t+15].
    typedef logic [15:0][31:0] win_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV256 [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] IV224 [0:7] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic wv_t iv_words(input logic m224);
        wv_t w;
        for (int unsigned i = 0; i < 8; i++) begin
            w[i] = m224 ? IV224[i] : IV256[i];
        end
        return w;
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: a..h, K[t], W[t] in, next a..h out.
module sha256_round
    import sha256_pkg::*;
(
    input  wv_t         st_i,
    input  logic [31:0] k_i,
    input  logic [31:0] w_i,
    output wv_t         st_o
);

    logic [31:0] t1;
    logic [31:0] t2;

    always_comb begin
        t1 = st_i[7] + big_sigma1(st_i[4]) + ch(st_i[4], st_i[5], st_i[6]) + k_i + w_i;
        t2 = big_sigma0(st_i[0]) + maj(st_i[0], st_i[1], st_i[2]);
        st_o[0] = t1 + t2;
        st_o[1] = st_i[0];
        st_o[2] = st_i[1];
        st_o[3] = st_i[2];
        st_o[4] = st_i[3] + t1;
        st_o[5] = st_i[4];
        st_o[6] = st_i[5];
        st_o[7] = st_i[6];
    end

endmodule

// File: rtl/sha256_core_iter.sv
// Iterative SHA-256/224 block core: UNROLL rounds per clock, chained
// multi-block messages, digest held in OUTPUT until the consumer takes it.
module sha256_core_iter
    import sha256_pkg::*;
#(
    parameter int unsigned UNROLL      = 1,
    parameter bit          SUPPORT_224 = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_block,
    input  logic         in_first,
    input  logic         in_last,
    input  logic         mode_224,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] digest,
    output logic         busy
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
        $error("sha256_core_iter: UNROLL must be 1, 2 or 4");
    end

    localparam logic [5:0] LAST_CNT = 6'(64 / UNROLL - 1);

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    wv_t        h_q, h_d;
    wv_t        wv_q, wv_d;
    win_t       w_q, w_d;
    logic       mode224_q, mode224_d;
    logic       last_q, last_d;
    logic       chain_q, chain_d;
    logic       mode_sel;

    wv_t  stage_st  [UNROLL+1];
    win_t stage_win [UNROLL+1];

    assign stage_st[0]  = wv_q;
    assign stage_win[0] = w_q;
    assign mode_sel     = SUPPORT_224 && mode_224;

    // Each stage consumes W[t] from the window head and shifts in W[t+16].
    for (genvar j = 0; j < UNROLL; j++) begin : g_round
        logic [5:0]  k_idx;
        logic [31:0] w_new;

        assign k_idx = cnt_q * 6'(UNROLL) + 6'(j);
        assign w_new = small_sigma1(stage_win[j][14]) + stage_win[j][9]
                     + small_sigma0(stage_win[j][1]) + stage_win[j][0];
        assign stage_win[j+1] = {w_new, stage_win[j][15:1]};

        sha256_round u_round (
            .st_i (stage_st[j]),
            .k_i  (K[k_idx]),
            .w_i  (stage_win[j][0]),
            .st_o (stage_st[j+1])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        h_d       = h_q;
        wv_d      = wv_q;
        w_d       = w_q;
        mode224_d = mode224_q;
        last_d    = last_q;
        chain_d   = chain_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int unsigned i = 0; i < 16; i++) begin
                        w_d[i] = in_block[511 - 32*i -: 32];
                    end
                    if (in_first || !chain_q) begin
                        mode224_d = mode_sel;
                        h_d       = iv_words(mode_sel);
                        wv_d      = iv_words(mode_sel);
                    end else begin
                        wv_d = h_q;
                    end
                    last_d  = in_last;
                    chain_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                wv_d  = stage_st[UNROLL];
                w_d   = stage_win[UNROLL];
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                for (int unsigned i = 0; i < 8; i++) begin
                    h_d[i] = h_q[i] + wv_q[i];
                end
                if (last_q) begin
                    chain_d = 1'b0;
                    state_d = OUTPUT;
                end else begin
                    state_d = IDLE;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            h_q       <= iv_words(1'b0);
            wv_q      <= '0;
            w_q       <= '0;
            mode224_q <= 1'b0;
            last_q    <= 1'b0;
            chain_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            h_q       <= h_d;
            wv_q      <= wv_d;
            w_q       <= w_d;
            mode224_q <= mode224_d;
            last_q    <= last_d;
            chain_q   <= chain_d;
        end
    end

    // Outputs are forced quiet while rst is high, before the register clears.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == OUTPUT) && !rst;
    assign busy      = (state_q != IDLE) && !rst;

    always_comb begin
        digest = '0;
        if (out_valid) begin
            for (int unsigned i = 0; i < 8; i++) begin
                digest[255 - 32*i -: 32] = h_q[i];
            end
            if (mode224_q) begin
                digest[31:0] = '0;
            end
        end
    end

endmodule

// File: tb/tb_sha256_core_iter.sv
// Scoreboard bench for sha256_core_iter, run in turn on UNROLL = 1, 2 and 4 instances.
module tb_sha256_core_iter;

    localparam int NU = 3;

    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
    localparam logic [511:0] TWO_BLK1  = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_BLK2  = {480'h0, 32'h000001c0};

    localparam logic [255:0] ABC_D   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO_D   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] ABC224  = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
    localparam logic [255:0] EMPTY_D = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         in_valid_v  [NU];
    logic         in_first_v  [NU];
    logic         in_last_v   [NU];
    logic         mode_v      [NU];
    logic         out_ready_v [NU];
    logic [511:0] blk_v       [NU];
    logic         in_ready_v  [NU];
    logic         out_valid_v [NU];
    logic         busy_v      [NU];
    logic [255:0] dig_v       [NU];

    for (genvar g = 0; g < NU; g++) begin : g_dut
        sha256_core_iter #(.UNROLL(1 << g), .SUPPORT_224(1'b1)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_v[g]),
            .in_block  (blk_v[g]),
            .in_first  (in_first_v[g]),
            .in_last   (in_last_v[g]),
            .mode_224  (mode_v[g]),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready_v[g]),
            .digest    (dig_v[g]),
            .busy      (busy_v[g])
        );
    end

    int n_chk = 0;
    int n_err = 0;
    int cur_u = 0;
    int nrounds = 64;
    logic [255:0] sb [$];

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL unroll=%0d %s: got %h expected %h", 1 << cur_u, tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [511:0] blk, input logic first, input logic last,
                        input logic m224);
        int guard = 0;
        while (!in_ready_v[cur_u] && guard < 300) begin
            tick();
            guard++;
        end
        chk("ready_before_send", 256'(in_ready_v[cur_u]), 256'(1));
        blk_v[cur_u]      = blk;
        in_first_v[cur_u] = first;
        in_last_v[cur_u]  = last;
        mode_v[cur_u]     = m224;
        in_valid_v[cur_u] = 1'b1;
        tick();
        in_valid_v[cur_u] = 1'b0;
    endtask

    // k0 = cycles already elapsed since the accepting edge.
    task automatic expect_digest(input string tag, input int k0);
        int k = k0;
        logic [255:0] exp;
        while (!out_valid_v[cur_u] && k < 300) begin
            tick();
            k++;
        end
        chk({tag, "_latency"}, 256'(k), 256'(nrounds + 1));
        chk({tag, "_sb_nonempty"}, 256'(sb.size() != 0), 256'(1));
        exp = (sb.size() != 0) ? sb.pop_front() : '0;
        chk(tag, dig_v[cur_u], exp);
    endtask

    task automatic run_all();
        int k;
        int seen;

        rst = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", 256'(in_ready_v[cur_u]), 256'(0));
        chk("rst_out_valid", 256'(out_valid_v[cur_u]), 256'(0));
        chk("rst_busy", 256'(busy_v[cur_u]), 256'(0));
        chk("rst_digest", dig_v[cur_u], 256'(0));
        rst = 1'b0;
        tick();
        chk("ready_after_rst", 256'(in_ready_v[cur_u]), 256'(1));

        // abc, with junk on the input side during ROUND that must be ignored
        out_ready_v[cur_u] = 1'b1;
        sb.push_back(ABC_D);
        send(ABC_BLK, 1'b1, 1'b1, 1'b0);
        chk("abc_busy", 256'(busy_v[cur_u]), 256'(1));
        chk("abc_not_ready", 256'(in_ready_v[cur_u]), 256'(0));
        blk_v[cur_u]      = {16{$urandom}};
        in_first_v[cur_u] = 1'b1;
        mode_v[cur_u]     = 1'b1;
        in_valid_v[cur_u] = 1'b1;
        for (int i = 1; i < nrounds; i++) tick();
        in_valid_v[cur_u] = 1'b0;
        expect_digest("abc", nrounds - 1);
        tick();
        chk("abc_released", 256'(out_valid_v[cur_u]), 256'(0));
        chk("abc_idle", 256'(in_ready_v[cur_u]), 256'(1));

        // two-block message: core frees at cycle N+1, no digest after block 1
        sb.push_back(TWO_D);
        send(TWO_BLK1, 1'b1, 1'b0, 1'b0);
        k = 0;
        seen = 0;
        while (!in_ready_v[cur_u] && k < 300) begin
            tick();
            k++;
            if (out_valid_v[cur_u]) seen++;
        end
        chk("blk1_free_cycle", 256'(k), 256'(nrounds + 1));
        chk("blk1_no_out_valid", 256'(seen), 256'(0));
        send(TWO_BLK2, 1'b0, 1'b1, 1'b0);
        expect_digest("two_block", 0);
        tick();

        sb.push_back(ABC224);
        send(ABC_BLK, 1'b1, 1'b1, 1'b1);
        expect_digest("abc224", 0);
        tick();

        // in_first mid-chain discards the chain
        send(TWO_BLK1, 1'b1, 1'b0, 1'b0);
        sb.push_back(ABC_D);
        send(ABC_BLK, 1'b1, 1'b1, 1'b0);
        expect_digest("restart", 0);
        tick();

        // empty message with back-pressure
        out_ready_v[cur_u] = 1'b0;
        sb.push_back(EMPTY_D);
        send(EMPTY_BLK, 1'b1, 1'b1, 1'b0);
        expect_digest("empty", 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_digest", dig_v[cur_u], EMPTY_D);
            chk("hold_valid", 256'(out_valid_v[cur_u]), 256'(1));
            chk("hold_not_ready", 256'(in_ready_v[cur_u]), 256'(0));
        end
        out_ready_v[cur_u] = 1'b1;
        tick();
        chk("empty_released", 256'(out_valid_v[cur_u]), 256'(0));
        chk("empty_idle", 256'(in_ready_v[cur_u]), 256'(1));

        // reset during round 20, then resend without in_first
        send(ABC_BLK, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < (20 >> cur_u); i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 256'(busy_v[cur_u]), 256'(0));
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (out_valid_v[cur_u]) seen++;
        end
        chk("abort_no_out_valid", 256'(seen), 256'(0));
        sb.push_back(ABC_D);
        send(ABC_BLK, 1'b0, 1'b1, 1'b0);
        expect_digest("abc_after_abort", 0);
        tick();
    endtask

    initial begin
        for (int i = 0; i < NU; i++) begin
            in_valid_v[i]  = 1'b0;
            in_first_v[i]  = 1'b0;
            in_last_v[i]   = 1'b0;
            mode_v[i]      = 1'b0;
            out_ready_v[i] = 1'b0;
            blk_v[i]       = '0;
        end
        for (int u = 0; u < NU; u++) begin
            cur_u   = u;
            nrounds = 64 >> u;
            run_all();
        end
        chk("sb_drained", 256'(sb.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
